mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port unified memory between the instruction-fetch requester (F stage, PC) and the data requester (M stage, load/store after byte-enable alignment). One transaction is outstanding at a time. Data has priority, with a starvation guard for fetch. The pipeline derives its stall from the per-side grant/valid handshakes.

## Interface
- `STARVE_LIMIT`, default 4: consecutive D grants allowed while `i_req` is pending before I is forced; must be ≥1.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  fetch request; hold with `i_addr` stable until `i_gnt`. May drop before grant (flush).
- `i_addr`  in  32  fetch address.
- `i_gnt`  out  1  fetch request accepted this cycle.
- `i_rvalid`  out  1  fetch data valid, one-cycle pulse.
- `i_rdata`  out  32  fetch data.
- `d_req`  in  1  data request; hold with payload stable until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  4  byte enables.
- `d_addr`, `d_wdata`  in  32  data address and store data.
- `d_gnt`  out  1  data request accepted.
- `d_rvalid`  out  1  load data or store ack, one-cycle pulse.
- `d_rdata`  out  32  load data; don't-care for stores.
- `m_req`  out  1  memory request; held until `m_gnt`.
- `m_we`  out  1  write enable.
- `m_be`  out  4  byte enables.
- `m_addr`, `m_wdata`  out  32  memory address and write data.
- `m_gnt`  in  1  memory accepted request.
- `m_rvalid`  in  1  response (reads and writes), ≥1 cycle after `m_gnt`.
- `m_rdata`  in  32  memory read data.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - REQ: `m_req`=1, wait for `m_gnt`.
  - RESP: wait for `m_rvalid`.
- Arbitration runs in two places: in IDLE, and in RESP in the cycle `m_rvalid`=1.
  - The winner gets a combinational `*_gnt` in that cycle.
  - Its payload is captured into the `m_*` registers and the owner register.
  - Next state is REQ.
  - If neither side requests, next state is IDLE.
- Priority: D over I, except when `starve_cnt`==`STARVE_LIMIT` and `i_req`=1; then I wins.
- `starve_cnt` update at each arbitration:
  - +1 on a D grant while `i_req`=1 (saturating).
  - Cleared on an I grant.
  - Cleared when `i_req`=0.
  - Width is $clog2(`STARVE_LIMIT`+1).
- REQ→RESP on `m_gnt`. `m_req` drops in the cycle after `m_gnt`.
- RESP: `m_rvalid` is routed combinationally by owner. `i_rvalid`/`d_rvalid` equal `m_rvalid` gated by owner and state==RESP; `*_rdata` = `m_rdata`.
- `m_rvalid` in IDLE or REQ is ignored, and no `*_rvalid` is produced.
- A granted transaction always completes, even if the requester later deasserts its request (flush). The pipeline discards the response.
- Request changes after grant have no effect on `m_*`.

## Timing
- Reset values:
  - state IDLE, owner I, `starve_cnt` 0.
  - `m_req`, `m_we` 0; `m_be` 0; `m_addr`, `m_wdata` 0.
  - `busy` 0; all `*_gnt` and `*_rvalid` 0. Grants are gated by `~rst`.
- Zero-wait memory:
  - Grant at cycle N.
  - `m_req` and `m_gnt` at N+1.
  - `m_rvalid` and `*_rvalid` at N+2.
  - Next grant possible at N+2.
  - Throughput is 1 transaction per 2 cycles.
- Wait states: each extra cycle of `m_gnt` or `m_rvalid` delay adds one cycle. `m_*` stay stable throughout REQ.
- Simultaneous `i_req` and `d_req`: exactly one grant per arbitration cycle, never both.
- Reset mid-transaction: return to IDLE immediately. The outstanding response is dropped, and a late `m_rvalid` after reset is ignored.

## Structure
- Shared package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, REQ, RESP}.
  - `arb_owner_t` enum {OWN_I, OWN_D}.
  - Width constants ADDR_W=32, DATA_W=32, BE_W=4.
- Sub-module `mem_arb_select`: combinational priority and starvation decision. Inputs are `i_req`, `d_req` and the `starve_cnt`-at-limit flag; outputs are the grant vector and `starve_cnt` next value.
- FSM, owner and payload registers live in the top module.

## Test plan
- Reset: hold `rst`=1 with `i_req`=`d_req`=1 → all outputs 0, no grants. Release → `i_gnt`=0, `d_gnt`=1 in the first cycle.
- Single fetch, zero-wait: `i_req`, `i_addr`=0x1000_0000 at cycle 0 → `i_gnt` at 0. Cycle 1: `m_req`=1, `m_addr`=0x1000_0000, `m_we`=0. With `m_rdata`=0x0000_0033 → `i_rvalid`=1, `i_rdata`=0x0000_0033 at cycle 2.
- Contention: `i_req` with a D store (`d_addr`=0x2000_0004, `d_be`=4'b1100, `d_wdata`=0xDEAD_BEEF) → D granted first, `m_we`=1, `m_be`=4'b1100. I is granted in the D `m_rvalid` cycle, and `d_rvalid` pulses once.
- Starvation, `STARVE_LIMIT`=4, `i_req` and `d_req` held → grant order D,D,D,D,I,D,D,D,D,I.
- Wait states: `m_gnt` delayed 3 cycles, then `d_addr` changed after `d_gnt` → `m_req` and `m_addr` stable for all 4 REQ cycles with the captured value, `busy`=1 throughout.
- Reset in RESP: assert `rst` while waiting, then pulse `m_rvalid` after release with no requests → state IDLE, `i_rvalid`=`d_rvalid`=0, `busy`=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/owner types and bus widths for the memory port arbiter
package mem_arb_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} arb_owner_t;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: data-first priority with a fetch starvation guard
module mem_arb_select #(
    parameter int STARVE_LIMIT = 4,
    localparam int CW = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          i_req,
    input  logic          d_req,
    input  logic          at_limit,
    input  logic [CW-1:0] starve_cnt,
    output logic [1:0]    gnt,
    output logic [CW-1:0] starve_nxt
);
    always_comb begin
        gnt[0]     = i_req & (~d_req | at_limit);
        gnt[1]     = d_req & ~gnt[0];
        starve_nxt = (~i_req | gnt[0]) ? '0 : at_limit ? starve_cnt : starve_cnt + CW'(1);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch (I) and data (D)
// requesters, one outstanding transaction at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [BE_W-1:0]   m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic [CW-1:0]     starve_q, starve_d, starve_sel;
    logic              m_we_q, m_we_d;
    logic [BE_W-1:0]   m_be_q, m_be_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [1:0]        gnt;
    logic              arb_en, at_limit, any_gnt;

    assign at_limit = (starve_q == CW'(STARVE_LIMIT));

    mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
        .i_req      (i_req),
        .d_req      (d_req),
        .at_limit   (at_limit),
        .starve_cnt (starve_q),
        .gnt        (gnt),
        .starve_nxt (starve_sel)
    );

    // Arbitrate when idle, or back-to-back in the response cycle of the current owner
    always_comb begin
        arb_en    = ~rst & ((state_q == IDLE) | ((state_q == RESP) & m_rvalid));
        i_gnt     = arb_en & gnt[0];
        d_gnt     = arb_en & gnt[1];
        any_gnt   = i_gnt | d_gnt;
        state_d   = state_q;
        owner_d   = owner_q;
        starve_d  = starve_q;
        m_we_d    = m_we_q;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        if ((state_q == REQ) && m_gnt)
            state_d = RESP;
        if (arb_en) begin
            starve_d = starve_sel;
            state_d  = any_gnt ? REQ : IDLE;
        end
        if (any_gnt) begin
            owner_d   = d_gnt ? OWN_D : OWN_I;
            m_we_d    = d_gnt & d_we;
            m_be_d    = d_gnt ? d_be : '1;
            m_addr_d  = d_gnt ? d_addr : i_addr;
            m_wdata_d = d_gnt ? d_wdata : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            starve_q  <= '0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign m_req    = (state_q == REQ);
    assign m_we     = m_we_q;
    assign m_be     = m_be_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign busy     = (state_q != IDLE);
    assign i_rvalid = (state_q == RESP) & m_rvalid & (owner_q == OWN_I);
    assign d_rvalid = (state_q == RESP) & m_rvalid & (owner_q == OWN_D);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand-written multi-cycle sequences
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, busy;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    logic        m_gnt, m_rvalid, mem_rv, man_rv, mem_mute;
    int          gnt_delay;
    logic [31:0] rdata_val;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic        ir, dr, we;
        logic [3:0]  be;
        logic [31:0] ia, da, wd, rd;
        logic        eig, edg, ewe;
        logic [3:0]  ebe;
        logic [31:0] ea, ewd;
    } vec_t;
    vec_t v[5];

    assign m_rvalid = mem_rv | man_rv;
    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
    );

    // Memory model: grant after gnt_delay REQ cycles, respond the cycle after grant
    initial begin
        int   wait_cnt;
        logic gnt_seen;
        wait_cnt = 0;
        gnt_seen = 1'b0;
        m_gnt = 1'b0;
        mem_rv = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            mem_rv = gnt_seen & ~mem_mute;
            m_rdata = rdata_val;
            gnt_seen = 1'b0;
            if (m_req && wait_cnt >= gnt_delay) begin
                m_gnt = 1'b1;
                gnt_seen = 1'b1;
                wait_cnt = 0;
            end else begin
                m_gnt = 1'b0;
                if (m_req) wait_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    initial begin
        int g, n;
        v[0] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h1000_0000, 32'h0, 32'h0, 32'h0000_0033,
                 1'b1, 1'b0, 1'b0, 4'hF, 32'h1000_0000, 32'h0};
        v[1] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h2000_0000, 32'h1234_5678, 32'hCAFE_F00D,
                 1'b0, 1'b1, 1'b0, 4'hF, 32'h2000_0000, 32'h1234_5678};
        v[2] = '{1'b1, 1'b1, 1'b1, 4'hC, 32'h1000_0004, 32'h2000_0004, 32'hDEAD_BEEF, 32'h0,
                 1'b0, 1'b1, 1'b1, 4'hC, 32'h2000_0004, 32'hDEAD_BEEF};
        v[3] = '{1'b0, 1'b1, 1'b1, 4'h1, 32'h0, 32'h0000_0003, 32'h0000_0011, 32'h0,
                 1'b0, 1'b1, 1'b1, 4'h1, 32'h0000_0003, 32'h0000_0011};
        v[4] = '{1'b0, 1'b0, 1'b0, 4'hF, 32'h1000_0008, 32'h2000_0008, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0};

        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
        i_addr = 32'h1000_0000; d_addr = 32'h2000_0000; d_wdata = '0;
        man_rv = 1'b0; mem_mute = 1'b0; gnt_delay = 0; rdata_val = '0;

        // Reset holds everything quiet despite pending requests
        repeat (3) @(negedge clk);
        #1;
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_m_req", m_req, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_be", m_be, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_i_gnt", i_gnt, 0);
        chk("rel_d_gnt", d_gnt, 1);
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        wait_idle();

        // Single zero-wait transactions from IDLE
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i_req = v[k].ir; d_req = v[k].dr; d_we = v[k].we; d_be = v[k].be;
            i_addr = v[k].ia; d_addr = v[k].da; d_wdata = v[k].wd; rdata_val = v[k].rd;
            #1;
            chk($sformatf("v%0d_i_gnt", k), i_gnt, v[k].eig);
            chk($sformatf("v%0d_d_gnt", k), d_gnt, v[k].edg);
            @(negedge clk);
            i_req = 1'b0; d_req = 1'b0;
            #1;
            if (v[k].eig | v[k].edg) begin
                chk($sformatf("v%0d_m_req", k), m_req, 1);
                chk($sformatf("v%0d_m_addr", k), m_addr, v[k].ea);
                chk($sformatf("v%0d_m_we", k), m_we, v[k].ewe);
                chk($sformatf("v%0d_m_be", k), m_be, v[k].ebe);
                chk($sformatf("v%0d_m_wdata", k), m_wdata, v[k].ewd);
                chk($sformatf("v%0d_busy", k), busy, 1);
                @(negedge clk);
                #1;
                chk($sformatf("v%0d_i_rvalid", k), i_rvalid, v[k].eig);
                chk($sformatf("v%0d_d_rvalid", k), d_rvalid, v[k].edg);
                if (!v[k].ewe)
                    chk($sformatf("v%0d_rdata", k), v[k].eig ? i_rdata : d_rdata, v[k].rd);
            end else begin
                chk($sformatf("v%0d_m_req", k), m_req, 0);
                chk($sformatf("v%0d_busy", k), busy, 0);
            end
        end
        wait_idle();

        // Contention: D store first, I granted in the D response cycle
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h1000_0040;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000_0004; d_be = 4'b1100; d_wdata = 32'hDEAD_BEEF;
        #1;
        chk("ct_d_gnt", d_gnt, 1);
        chk("ct_i_gnt", i_gnt, 0);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        chk("ct_m_we", m_we, 1);
        chk("ct_m_be", m_be, 4'b1100);
        chk("ct_m_addr", m_addr, 32'h2000_0004);
        chk("ct_m_wdata", m_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        #1;
        chk("ct_d_rvalid", d_rvalid, 1);
        chk("ct_i_gnt2", i_gnt, 1);
        chk("ct_d_gnt2", d_gnt, 0);
        @(negedge clk);
        i_req = 1'b0;
        #1;
        chk("ct_d_rvalid_once", d_rvalid, 0);
        chk("ct_i_m_addr", m_addr, 32'h1000_0040);
        chk("ct_i_m_we", m_we, 0);
        @(negedge clk);
        #1;
        chk("ct_i_rvalid", i_rvalid, 1);
        chk("ct_d_rvalid_none", d_rvalid, 0);
        wait_idle();

        // Wait states: grant delayed 3 cycles, request payload changes after grant
        gnt_delay = 3;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h4000_0100;
        #1;
        chk("ws_d_gnt", d_gnt, 1);
        @(negedge clk);
        d_req = 1'b0; d_addr = 32'h5555_0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("ws%0d_m_req", k), m_req, 1);
            chk($sformatf("ws%0d_m_addr", k), m_addr, 32'h4000_0100);
            chk($sformatf("ws%0d_busy", k), busy, 1);
            @(negedge clk);
        end
        #1;
        chk("ws_m_req_drop", m_req, 0);
        chk("ws_d_rvalid", d_rvalid, 1);
        gnt_delay = 0;
        wait_idle();

        // Starvation: both held, fetch forced every fifth grant
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000_0010;
        g = 0;
        n = 0;
        while (g < 10 && n < 60) begin
            #1;
            if (i_gnt | d_gnt) begin
                chk($sformatf("sv%0d_both", g), i_gnt & d_gnt, 0);
                chk($sformatf("sv%0d_i_wins", g), i_gnt, (g == 4 || g == 9) ? 1 : 0);
                g++;
            end
            @(negedge clk);
            n++;
        end
        chk("sv_grant_count", g, 10);
        i_req = 1'b0; d_req = 1'b0;
        wait_idle();

        // Reset while waiting for a response, then a stray late response
        mem_mute = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h6000_0000;
        #1;
        chk("rr_d_gnt", d_gnt, 1);
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        #1;
        chk("rr_busy_resp", busy, 1);
        rst = 1'b1;
        #1;
        chk("rr_busy_rst", busy, 0);
        chk("rr_m_addr_rst", m_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        man_rv = 1'b1;
        #1;
        chk("rr_late_rvalid", {i_rvalid, d_rvalid}, 0);
        chk("rr_late_busy", busy, 0);
        @(negedge clk);
        man_rv = 1'b0;
        mem_mute = 1'b0;
        #1;
        chk("rr_idle", busy, 0);
        chk("rr_no_req", m_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
